// File: rtl/cordic_stage.sv
// cordic_stage: one registered rotation-mode CORDIC micro-rotation.
// Rotates (x, y) toward the residual angle z by +/-atan(2^-shift).
module cordic_stage #(
  parameter int bitwidth = 16,
  parameter int zwidth   = 16,
  parameter int shift    = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic signed [bitwidth-1:0] xi,
  input  logic signed [bitwidth-1:0] yi,
  input  logic signed [zwidth-1:0]   zi,
  input  logic        [zwidth-1:0]   constant,
  output logic signed [bitwidth-1:0] xo,
  output logic signed [bitwidth-1:0] yo,
  output logic signed [zwidth-1:0]   zo
);

  logic                       z_pos;
  logic signed [bitwidth-1:0] xs;
  logic signed [bitwidth-1:0] ys;
  logic        [bitwidth-1:0] x_nxt;
  logic        [bitwidth-1:0] y_nxt;
  logic        [zwidth-1:0]   z_nxt;

  // direction pick and sign-filled cross terms
  always_comb begin
    z_pos = ~zi[zwidth-1];
    xs    = xi >>> shift;
    ys    = yi >>> shift;
    x_nxt = xi;
    y_nxt = yi;
    z_nxt = zi;
    if (z_pos) begin
      x_nxt = xi - ys;
      y_nxt = yi + xs;
      z_nxt = zi - constant;
    end else begin
      x_nxt = xi + ys;
      y_nxt = yi - xs;
      z_nxt = zi + constant;
    end
  end

  // output registers, wrap-around arithmetic
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xo <= '0;
      yo <= '0;
      zo <= '0;
    end else if (enable) begin
      xo <= x_nxt;
      yo <= y_nxt;
      zo <= z_nxt;
    end
  end

endmodule

// File: tb/tb_cordic_stage.sv
// tb_cordic_stage: three stages (shift 1, 0, 11) share inputs
// and are compared against an integer reference model.
module tb_cordic_stage;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic signed [15:0] xi = 16'sd0;
  logic signed [15:0] yi = 16'sd0;
  logic signed [15:0] zi = 16'sd0;
  logic [15:0] constant = 16'd0;
  logic signed [15:0] xo1, yo1, zo1;
  logic signed [15:0] xo0, yo0, zo0;
  logic signed [15:0] xob, yob, zob;

  int checks = 0;
  int failures = 0;
  int ex[3], ey[3], ez[3];
  int shs[3] = '{1, 0, 11};

  always #5 clock = ~clock;

  cordic_stage #(.bitwidth(16), .zwidth(16), .shift(1)) u_s1 (
    .clock(clock), .reset(reset), .enable(enable),
    .xi(xi), .yi(yi), .zi(zi), .constant(constant),
    .xo(xo1), .yo(yo1), .zo(zo1));

  cordic_stage #(.bitwidth(16), .zwidth(16), .shift(0)) u_s0 (
    .clock(clock), .reset(reset), .enable(enable),
    .xi(xi), .yi(yi), .zi(zi), .constant(constant),
    .xo(xo0), .yo(yo0), .zo(zo0));

  cordic_stage #(.bitwidth(16), .zwidth(16), .shift(11)) u_s11 (
    .clock(clock), .reset(reset), .enable(enable),
    .xi(xi), .yi(yi), .zi(zi), .constant(constant),
    .xo(xob), .yo(yob), .zo(zob));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int wrap16(input longint v);
    longint m;
    m = ((v % 65536) + 65536) % 65536;
    if (m >= 32768) m = m - 65536;
    return int'(m);
  endfunction

  function automatic int fdiv(input int v, input int sh);
    int p;
    p = 1 << sh;
    if (v >= 0) return v / p;
    return -((-v + p - 1) / p);
  endfunction

  // reference: plain-arithmetic micro-rotation
  task automatic model(input int sh, input int x, input int y,
                       input int z, input int c,
                       output int xr, output int yr, output int zr);
    int xs, ys;
    xs = fdiv(x, sh);
    ys = fdiv(y, sh);
    if (z >= 0) begin
      xr = wrap16(longint'(x) - ys);
      yr = wrap16(longint'(y) + xs);
      zr = wrap16(longint'(z) - c);
    end else begin
      xr = wrap16(longint'(x) + ys);
      yr = wrap16(longint'(y) - xs);
      zr = wrap16(longint'(z) + c);
    end
  endtask

  task automatic drive(input int x, input int y, input int z,
                       input int c, input bit en);
    @(negedge clock);
    xi = 16'(x);
    yi = 16'(y);
    zi = 16'(z);
    constant = 16'(c);
    enable = en;
    if (en && !reset)
      for (int k = 0; k < 3; k++)
        model(shs[k], wrap16(x), wrap16(y), wrap16(z), c & 16'hffff,
              ex[k], ey[k], ez[k]);
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_x1"}, xo1, ex[0]);
    chk({tag, "_y1"}, yo1, ey[0]);
    chk({tag, "_z1"}, zo1, ez[0]);
    chk({tag, "_x0"}, xo0, ex[1]);
    chk({tag, "_y0"}, yo0, ey[1]);
    chk({tag, "_z0"}, zo0, ez[1]);
    chk({tag, "_x11"}, xob, ex[2]);
    chk({tag, "_y11"}, yob, ey[2]);
    chk({tag, "_z11"}, zob, ez[2]);
  endtask

  task automatic zero_exp();
    for (int k = 0; k < 3; k++) begin
      ex[k] = 0;
      ey[k] = 0;
      ez[k] = 0;
    end
  endtask

  initial begin
    zero_exp();
    xi = 16'sd1234;
    yi = -16'sd77;
    zi = 16'sd500;
    constant = 16'd4836;
    enable = 1'b1;
    #12;
    check_all("rst_init");

    @(negedge clock);
    reset = 1'b0;
    drive(1000, 200, 100, 4836, 1'b1);
    chk("pos_x", xo1, 900);
    chk("pos_y", yo1, 700);
    chk("pos_z", zo1, -4736);
    check_all("pos");

    // asynchronous reset between edges
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    zero_exp();
    check_all("rst_async");
    @(posedge clock);
    #1;
    check_all("rst_hold");
    @(negedge clock);
    reset = 1'b0;

    drive(1000, 200, -100, 4836, 1'b1);
    chk("neg_x", xo1, 1100);
    chk("neg_y", yo1, -300);
    chk("neg_z", zo1, 4736);
    check_all("neg");

    drive(1000, -3, 0, 4836, 1'b1);
    chk("ash_x", xo1, 1002);
    chk("ash_y", yo1, 497);
    chk("ash_z", zo1, -4836);
    check_all("ash");

    drive(32767, -2, 0, 0, 1'b1);
    chk("wrap_x", xo0, -32767);
    chk("wrap_y", yo0, 32765);
    chk("wrap_z", zo0, 0);
    check_all("wrap");

    // hold with enable low while inputs wander
    drive(-5000, 12000, 3000, 1500, 1'b1);
    check_all("load");
    for (int i = 0; i < 5; i++) begin
      drive($urandom_range(0, 65535), $urandom_range(0, 65535),
            $urandom_range(0, 65535), $urandom_range(0, 65535), 1'b0);
      check_all("hold");
    end
    drive(-20000, -1, -32768, 65535, 1'b1);
    check_all("reen");

    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 65535), $urandom_range(0, 65535),
            $urandom_range(0, 65535), $urandom_range(0, 65535),
            ($urandom_range(0, 3) != 0));
      check_all("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_stage.md
Name: cordic_stage

Overview:
- One pipelined rotation-mode CORDIC micro-rotation.
- Registers the rotated (x, y) pair and the updated residual angle z.
- Twelve instances are chained in a rotator/NCO mixer, with shift = 0..11 and per-stage atan constants.
- One clock of latency per stage.

Parameters:
bitwidth, 16, width of the signed two's-complement x/y datapath (the parent passes sample width + 2 for growth headroom)
zwidth, 16, width of the signed two's-complement z (angle) datapath and of the constant port
shift, 1, micro-rotation index i; the cross terms are arithmetically shifted right by i (valid range 0..bitwidth-1)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
enable  input  1  clock enable; registers update only when high
xi  input  bitwidth  signed x in
yi  input  bitwidth  signed y in
zi  input  zwidth  signed residual angle in
constant  input  zwidth  atan(2^-shift) in z units (unsigned magnitude, treated as a zwidth-bit value)
xo  output  bitwidth  registered signed x out
yo  output  bitwidth  registered signed y out
zo  output  zwidth  registered signed residual angle out

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports named clock and reset).
- Reset asserted (any time, independent of clock/enable): xo = yo = zo = 0 immediately; they hold 0 while reset is high.
- Direction: z_pos = ~zi[zwidth-1]. zi = 0 counts as positive.
- Shifted terms:
  - xs = xi >>> shift (arithmetic, sign-filled, i.e. floor(xi / 2^shift)).
  - ys = yi >>> shift (same rule).
  - shift = 0 means no shift.
- On a rising clock edge with reset low and enable high:
  - If z_pos: xo <= xi - ys; yo <= yi + xs; zo <= zi - constant.
  - Else: xo <= xi + ys; yo <= yi - xs; zo <= zi + constant.
- All arithmetic is modulo 2^bitwidth (x/y) or 2^zwidth (z): no saturation, results truncated to port width. Overflow headroom is the parent's responsibility.
- Enable low: all outputs hold their values; inputs are ignored.
- Latency: exactly 1 cycle from input to output; throughput 1 sample per enabled cycle.
- Purely combinational inputs to registered outputs. No internal state besides the three output registers.
- No gain compensation (the ~1.647 CORDIC gain is handled downstream).

Test Plan:
- Reset: drive non-zero inputs, pulse reset asynchronously between clock edges -> xo = yo = zo = 0 immediately, before the next edge; they stay 0 while reset is held.
- Positive z, defaults (shift=1): xi=1000, yi=200, zi=100, constant=4836, enable=1 -> after one edge xo=900, yo=700, zo=-4736.
- Negative z: xi=1000, yi=200, zi=-100, constant=4836 -> xo=1100, yo=-300, zo=4736.
- Arithmetic shift of a negative operand (shift=1): xi=1000, yi=-3, zi=0 -> ys=-2, so xo=1002; yo=-3+500=497; zo=-constant.
- Wrap-around (shift=0): xi=32767, yi=-2, zi=0, constant=0 -> xo=-32767 (wrapped), yo=-2+32767=32765, zo=0.
- Enable hold: load any values, then set enable=0 and change all inputs for 5 cycles -> outputs unchanged; re-assert enable -> updated on the next edge.
